// File: rtl/eval_scheduler_pkg.sv
// Shared types and default sizing for the event evaluation scheduler.
package eval_scheduler_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_NUM_LAYERS = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LAYER = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/event_fifo.sv
// Power-of-two event queue with occupancy count; a push on a full queue is
// accepted only when a pop frees the head in the same cycle.
module event_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       push_ok_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/eval_scheduler.sv
// Pops queued input events and sequences them through NUM_LAYERS evaluation
// layers, one layer per cycle, with a done pulse per event.
module eval_scheduler
  import eval_scheduler_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_LAYERS = DEF_NUM_LAYERS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] input_x,
  input  logic                     new_input,
  output logic [2:0]               llc_state,
  output logic                     qPush,
  output logic                     qPop,
  output logic                     qPushValid,
  output logic                     qPopValid,
  output logic signed [DATA_W-1:0] llc_x,
  output logic [NUM_LAYERS-1:0]    pacing,
  output logic                     eval_done,
  output logic                     overflow
);

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  state_t                  state_q;
  logic [LW-1:0]           layer_q;
  logic [DATA_W-1:0]       llc_x_q;
  logic                    overflow_q;
  logic [DATA_W-1:0]       fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  event_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (qPush),
    .pop_i    (qPop),
    .data_i   (input_x),
    .data_o   (fifo_head),
    .push_ok_o(qPushValid),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Outputs decode the registered state; en low masks them in the same cycle.
  assign qPush     = new_input && en;
  assign qPop      = en && (state_q == ST_POP);
  assign qPopValid = qPop && !fifo_empty;
  assign pacing    = (en && state_q == ST_LAYER) ? (NUM_LAYERS'(1) << layer_q) : '0;
  assign eval_done = en && (state_q == ST_DONE);
  assign llc_state = state_q;
  assign llc_x     = llc_x_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      layer_q    <= '0;
      llc_x_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (qPush && fifo_full && !qPop) overflow_q <= 1'b1;
      if (en) begin
        case (state_q)
          ST_IDLE: if (fifo_count != '0) state_q <= ST_POP;
          ST_POP: begin
            llc_x_q <= fifo_head;
            layer_q <= '0;
            state_q <= ST_LAYER;
          end
          ST_LAYER: begin
            if (layer_q == LW'(NUM_LAYERS-1)) begin
              layer_q <= '0;
              state_q <= ST_DONE;
            end else begin
              layer_q <= layer_q + LW'(1);
            end
          end
          ST_DONE: state_q <= fifo_empty ? ST_IDLE : ST_POP;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eval_scheduler.sv
// Scenario bench for eval_scheduler: expected event values are queued when
// pushes are driven and checked against llc_x at every eval_done pulse.
module tb_eval_scheduler;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int NL    = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic signed [DW-1:0] input_x;
  logic                 new_input;
  logic [2:0]           llc_state;
  logic                 qPush, qPop, qPushValid, qPopValid;
  logic signed [DW-1:0] llc_x;
  logic [NL-1:0]        pacing;
  logic                 eval_done;
  logic                 overflow;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int done_seen = 0;
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] mon_exp;

  eval_scheduler #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_LAYERS(NL)) dut (
    .clk(clk), .rst(rst), .en(en), .input_x(input_x), .new_input(new_input),
    .llc_state(llc_state), .qPush(qPush), .qPop(qPop), .qPushValid(qPushValid),
    .qPopValid(qPopValid), .llc_x(llc_x), .pacing(pacing),
    .eval_done(eval_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every done pulse must present the oldest expected value.
  always @(negedge clk) begin
    if (!rst && eval_done) begin
      done_seen++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow: got done with llc_x=%0d, expected no event", llc_x);
      end else begin
        mon_exp = exp_q.pop_front();
        if (llc_x !== mon_exp) $display("FAIL sb_value: got %0d expected %0d", llc_x, mon_exp);
        else pass_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; new_input = 1'b0; input_x = '0;
    repeat (2) @(negedge clk);
    check_cnt++; if (llc_state !== 3'd0) $display("FAIL rst_state: got %0d expected 0", llc_state); else pass_cnt++;
    check_cnt++; if (llc_x !== '0) $display("FAIL rst_llc_x: got %0d expected 0", llc_x); else pass_cnt++;
    check_cnt++; if ({pacing, eval_done, overflow, qPop, qPopValid} !== '0)
      $display("FAIL rst_outputs: got %b expected 0", {pacing, eval_done, overflow, qPop, qPopValid});
    else pass_cnt++;
    check_cnt++; if (dut.u_fifo.count_o !== 3'd0) $display("FAIL rst_count: got %0d expected 0", dut.u_fifo.count_o); else pass_cnt++;
    step();
    rst = 1'b0; en = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [NL-1:0] exp_p;
    int d0 = done_seen;
    input_x = 1; new_input = 1'b1; exp_q.push_back(1);
    @(negedge clk);
    check_cnt++; if (qPushValid !== 1'b1) $display("FAIL single_push: got %b expected 1", qPushValid); else pass_cnt++;
    for (int c = 1; c <= 7; c++) begin
      step();
      new_input = 1'b0;
      @(negedge clk);
      exp_p = (c >= 3 && c < 3 + NL) ? NL'(1) << (c - 3) : '0;
      check_cnt++; if (pacing !== exp_p) $display("FAIL single_pacing c%0d: got %b expected %b", c, pacing, exp_p); else pass_cnt++;
      check_cnt++; if (eval_done !== (c == 3 + NL)) $display("FAIL single_done c%0d: got %b expected %b", c, eval_done, c == 3 + NL); else pass_cnt++;
      check_cnt++; if (qPop !== (c == 2)) $display("FAIL single_pop c%0d: got %b expected %b", c, qPop, c == 2); else pass_cnt++;
      if (c == 3) begin
        check_cnt++; if (llc_x !== 1) $display("FAIL single_llc_x: got %0d expected 1", llc_x); else pass_cnt++;
      end
    end
    check_cnt++; if (done_seen - d0 !== 1) $display("FAIL single_done_count: got %0d expected 1", done_seen - d0); else pass_cnt++;
    step();
  endtask

  task automatic test_spaced();
    int d0 = done_seen;
    for (int v = 1; v <= 6; v++) begin
      input_x = v; new_input = 1'b1; exp_q.push_back(v);
      @(negedge clk);
      check_cnt++; if (qPushValid !== 1'b1) $display("FAIL spaced_push v%0d: got %b expected 1", v, qPushValid); else pass_cnt++;
      step();
      new_input = 1'b0;
      repeat (5) step();
    end
    wait_drain(40);
    check_cnt++; if (done_seen - d0 !== 6) $display("FAIL spaced_done_count: got %0d expected 6", done_seen - d0); else pass_cnt++;
    check_cnt++; if (overflow !== 1'b0) $display("FAIL spaced_overflow: got %b expected 0", overflow); else pass_cnt++;
    check_cnt++; if (dut.u_fifo.count_o !== 3'd0) $display("FAIL spaced_empty: got %0d expected 0", dut.u_fifo.count_o); else pass_cnt++;
  endtask

  task automatic test_burst();
    int occ = 0;
    int drops = 0;
    logic acc, pop_now;
    for (int k = 0; k < 5; k++) begin
      input_x = 10 + k; new_input = 1'b1;
      pop_now = (k == 2);
      acc = (occ < DEPTH) || pop_now;
      if (acc) exp_q.push_back(10 + k); else drops++;
      occ = occ + int'(acc) - int'(pop_now);
      @(negedge clk);
      check_cnt++; if (qPushValid !== acc) $display("FAIL burst_push k%0d: got %b expected %b", k, qPushValid, acc); else pass_cnt++;
      step();
    end
    new_input = 1'b0;
    wait_drain(80);
    check_cnt++; if (overflow !== (drops > 0)) $display("FAIL burst_overflow: got %b expected %b", overflow, drops > 0); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    for (int c = 0; c <= 8; c++) begin
      new_input = (c <= 4) || (c == 7);
      input_x = (c == 7) ? 25 : 20 + c;
      if (new_input) exp_q.push_back(input_x);
      @(negedge clk);
      if (c == 7) begin
        check_cnt++; if (qPop !== 1'b1) $display("FAIL fullpop_pop: got %b expected 1", qPop); else pass_cnt++;
        check_cnt++; if (qPushValid !== 1'b1) $display("FAIL fullpop_push: got %b expected 1", qPushValid); else pass_cnt++;
      end
      if (c == 8) begin
        check_cnt++; if (dut.u_fifo.count_o !== 3'd4) $display("FAIL fullpop_count: got %0d expected 4", dut.u_fifo.count_o); else pass_cnt++;
        check_cnt++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b expected 0", overflow); else pass_cnt++;
      end
      step();
    end
    new_input = 1'b0;
    wait_drain(80);
  endtask

  task automatic test_overflow();
    for (int c = 0; c <= 6; c++) begin
      new_input = (c <= 5);
      input_x = 30 + c;
      if (c <= 4) exp_q.push_back(input_x);
      @(negedge clk);
      if (c == 5) begin
        check_cnt++; if (qPushValid !== 1'b0) $display("FAIL ovf_push: got %b expected 0", qPushValid); else pass_cnt++;
      end
      if (c == 6) begin
        check_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else pass_cnt++;
        check_cnt++; if (dut.u_fifo.count_o !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", dut.u_fifo.count_o); else pass_cnt++;
      end
      step();
    end
    new_input = 1'b0;
    wait_drain(80);
    check_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else pass_cnt++;
  endtask

  task automatic test_en_freeze();
    logic [NL-1:0] exp_p;
    int pops = 0;
    input_x = 40; new_input = 1'b1; exp_q.push_back(40);
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      step();
      en = !(c >= 4 && c <= 8);
      new_input = (c == 6);
      input_x = 99;
      @(negedge clk);
      if (qPop) pops++;
      case (c)
        3:       exp_p = 3'b001;
        9:       exp_p = 3'b010;
        10:      exp_p = 3'b100;
        default: exp_p = 3'b000;
      endcase
      check_cnt++; if (pacing !== exp_p) $display("FAIL freeze_pacing c%0d: got %b expected %b", c, pacing, exp_p); else pass_cnt++;
      check_cnt++; if (eval_done !== (c == 11)) $display("FAIL freeze_done c%0d: got %b expected %b", c, eval_done, c == 11); else pass_cnt++;
      if (c >= 4 && c <= 8) begin
        check_cnt++; if (llc_state !== 3'd2) $display("FAIL freeze_state c%0d: got %0d expected 2", c, llc_state); else pass_cnt++;
        check_cnt++; if ({qPush, qPushValid, qPop} !== 3'b000) $display("FAIL freeze_q c%0d: got %b expected 000", c, {qPush, qPushValid, qPop}); else pass_cnt++;
      end
      if (c >= 3 && c <= 11) begin
        check_cnt++; if (llc_x !== 40) $display("FAIL freeze_llc_x c%0d: got %0d expected 40", c, llc_x); else pass_cnt++;
      end
    end
    check_cnt++; if (pops !== 1) $display("FAIL freeze_pops: got %0d expected 1", pops); else pass_cnt++;
    new_input = 1'b0; en = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 3; c++) begin
      new_input = (c <= 2);
      input_x = 50 + c;
      step();
    end
    new_input = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_cnt++; if (llc_state !== 3'd0) $display("FAIL midrst_state: got %0d expected 0", llc_state); else pass_cnt++;
    check_cnt++; if ({pacing, eval_done, qPop, overflow} !== '0) $display("FAIL midrst_outputs: got %b expected 0", {pacing, eval_done, qPop, overflow}); else pass_cnt++;
    check_cnt++; if (llc_x !== '0) $display("FAIL midrst_llc_x: got %0d expected 0", llc_x); else pass_cnt++;
    check_cnt++; if (dut.u_fifo.count_o !== 3'd0) $display("FAIL midrst_count: got %0d expected 0", dut.u_fifo.count_o); else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    input_x = 60; new_input = 1'b1; exp_q.push_back(60);
    step();
    new_input = 1'b0;
    wait_drain(20);
  endtask

  initial begin
    test_reset();
    test_single();
    test_spaced();
    test_burst();
    test_full_pop();
    test_overflow();
    test_en_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/eval_scheduler.md
EVAL_SCHEDULER -- requirements
Module: eval_scheduler

Interface
REQ-001 Parameter DATA_W, default 64: signed input stream value width.
REQ-002 Parameter DEPTH, default 4: input event queue depth, power of two, at least 2.
REQ-003 Parameter NUM_LAYERS, default 3: number of evaluation layers sequenced per event.
REQ-004 Port clk  input  1: single clock, rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port en  input  1: global enable; when low, all state holds and no input is accepted.
REQ-007 Port input_x  input  DATA_W: signed input event value.
REQ-008 Port new_input  input  1: input event strobe, one event per high cycle.
REQ-009 Port llc_state  output  3: current FSM state encoding.
REQ-010 Port qPush  output  1: push request (new_input AND en).
REQ-011 Port qPop  output  1: pop issued this cycle.
REQ-012 Port qPushValid  output  1: push accepted this cycle.
REQ-013 Port qPopValid  output  1: popped data valid this cycle.
REQ-014 Port llc_x  output  DATA_W: value of the event under evaluation.
REQ-015 Port pacing  output  NUM_LAYERS: one-hot layer enable for the output-stream datapath.
REQ-016 Port eval_done  output  1: one-cycle pulse, all layers evaluated for current event.
REQ-017 Port overflow  output  1: sticky flag, an event was dropped on a full queue.

Function
REQ-018 States SHALL be IDLE=0, POP=1, LAYER=2, DONE=3; the layer index is a separate counter 0..NUM_LAYERS-1.
REQ-019 Queue SHALL be FIFO order, count range 0..DEPTH, pointers wrap modulo DEPTH.
REQ-020 qPushValid SHALL equal qPush AND (count<DEPTH OR qPop).
- Full queue with a simultaneous pop accepts the push.
REQ-021 A push while full without a pop SHALL be dropped and SHALL set overflow; count stays unchanged.
REQ-022 IDLE: if count>0 and en, go to POP; otherwise hold.
REQ-023 POP: assert qPop and qPopValid; latch head into llc_x at the clock edge; clear the layer counter; go to LAYER.
REQ-024 LAYER: pacing SHALL be one-hot at bit[layer]; increment layer each cycle; after layer NUM_LAYERS-1, go to DONE.
REQ-025 DONE: eval_done=1 for exactly one cycle; go to POP if count>0 (back-to-back), else IDLE.
REQ-026 Latency: a push accepted at cycle t into an empty queue with FSM in IDLE gives POP at t+2, pacing bit0 at t+3, and eval_done at t+3+NUM_LAYERS.
REQ-027 Steady-state throughput SHALL be one event per NUM_LAYERS+2 cycles.
REQ-028 llc_x SHALL hold its value from POP until the next POP.
REQ-029 pacing SHALL be zero outside LAYER; qPop and qPopValid SHALL be zero outside POP.
REQ-030 A push and a pop in the same cycle SHALL leave count unchanged and update both pointers.
REQ-031 en low SHALL freeze the FSM, layer counter, queue, and llc_x.
- While en is low, pacing, qPop, qPopValid and eval_done SHALL be forced to 0; qPush=0.
REQ-032 Queue SHALL never pop when empty; POP is entered only with count>0.

Reset
REQ-033 Asserting rst SHALL immediately drive the following outputs and state:
- state IDLE, llc_state=0
- count=0, both pointers=0, layer=0
- llc_x=0, pacing=0, eval_done=0, overflow=0
- qPop=0, qPopValid=0
REQ-034 Reset mid-evaluation SHALL discard the in-flight event and all queued events.
REQ-035 Release of rst SHALL take effect at the next rising edge; no event is accepted in the release cycle unless new_input and en are high.

Structure
REQ-036 A shared package SHALL hold:
- state encoding typedef
- default DATA_W, DEPTH, NUM_LAYERS constants
REQ-037 The queue SHALL be a sub-module named event_fifo with push/pop/full/empty/count ports.
- The FSM, layer counter, and output decode SHALL be in eval_scheduler.

Verification
REQ-038 Reset, then input_x=1 with one new_input pulse -> qPushValid=1, POP 2 cycles later, llc_x=1, pacing 001,010,100 on consecutive cycles, eval_done once.
REQ-039 Inputs 1..6 spaced 6 cycles apart -> six eval_done pulses in order, llc_x=1..6, overflow=0, queue empty at end.
REQ-040 Five pushes on consecutive cycles (values 10..14) with DEPTH=4 -> events processed in order; the number of dropped pushes matches the occupancy computed from pop timing, and overflow=1 exactly when a drop occurred.
REQ-041 Push on the same cycle as a POP with a full queue -> push accepted, count stays at 4, no overflow.
REQ-042 en held low for 5 cycles during LAYER with layer=1 -> pacing=0 and state frozen; on en high, pacing resumes at 010 and the value is not re-popped.
REQ-043 rst asserted during LAYER with 2 events queued -> outputs are zero immediately and the queue is empty; a new push after release is evaluated normally.
